// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller.
// Accepts one load/store at a time from the pipeline, drives a simple req/ack bus
// with word-aligned address, byte enables and lane-replicated store data, and
// returns sign/zero-extended load data.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a bus access that is
// not acknowledged within TIMEOUT cycles (pulses o_err).
module mem_access_ctrl #(
    parameter int unsigned ACCESS_LAT = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_mem_data_access,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_busy,
    output logic        o_misaligned,
    output logic        o_err
);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic [3:0]  data_access_q, data_access_d;
    logic        misaligned_q, misaligned_d;

    logic        aligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] lane_word;
    logic [31:0] load_ext;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`else
    // Keeps the timeout parameter referenced when the counter is not built.
    logic [7:0]  unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
`endif

    // Decode alignment, byte enables and store-lane replication of the incoming request.
    always_comb begin
        aligned   = 1'b0;
        be_new    = 4'b1111;
        wdata_new = i_wdata;
        case (i_size)
            2'b00: begin
                aligned   = 1'b1;
                be_new    = 4'b0001 << i_addr[1:0];
                wdata_new = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                aligned   = ~i_addr[0];
                be_new    = 4'b0011 << i_addr[1:0];
                wdata_new = {2{i_wdata[15:0]}};
            end
            2'b10: begin
                aligned   = (i_addr[1:0] == 2'b00);
            end
            default: begin
                aligned   = 1'b0;
            end
        endcase
    end

    // Select the addressed lane of the bus read word and extend it.
    always_comb begin
        lane_word = i_mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, lane_word[7:0]}
                                      : {{24{lane_word[7]}}, lane_word[7:0]};
            2'b01:   load_ext = uns_q ? {16'd0, lane_word[15:0]}
                                      : {{16{lane_word[15]}}, lane_word[15:0]};
            default: load_ext = i_mem_rdata;
        endcase
    end

    // Next-state and registered-output logic of the IDLE/BUS/DONE controller.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        off_d         = off_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        size_d        = size_q;
        uns_d         = uns_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        req_d         = req_q;
        busy_d        = busy_q;
        data_access_d = 4'd0;
        misaligned_d  = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    if (aligned) begin
                        state_d       = StBus;
                        addr_d        = {i_addr[31:2], 2'b00};
                        off_d         = i_addr[1:0];
                        be_d          = be_new;
                        wdata_d       = wdata_new;
                        we_d          = i_we;
                        size_d        = i_size;
                        uns_d         = i_unsigned;
                        req_d         = 1'b1;
                        busy_d        = 1'b1;
                        data_access_d = 4'(ACCESS_LAT);
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt_d         = 8'd0;
`endif
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            StBus: begin
                // An ack always wins over a timeout in the same cycle.
                if (i_mem_ack) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d       = load_ext;
                        rdata_valid_d = 1'b1;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = 8'(TIMEOUT);
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            addr_q        <= 32'd0;
            off_q         <= 2'd0;
            be_q          <= 4'd0;
            wdata_q       <= 32'd0;
            we_q          <= 1'b0;
            size_q        <= 2'd0;
            uns_q         <= 1'b0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
            data_access_q <= 4'd0;
            misaligned_q  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q         <= 8'd0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            off_q         <= off_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            req_q         <= req_d;
            busy_q        <= busy_d;
            data_access_q <= data_access_d;
            misaligned_q  <= misaligned_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q         <= cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    assign o_mem_data_access = data_access_q;
    assign o_mem_req         = req_q;
    assign o_mem_we          = we_q;
    assign o_mem_addr        = addr_q;
    assign o_mem_be          = be_q;
    assign o_mem_wdata       = wdata_q;
    assign o_rdata           = rdata_q;
    assign o_rdata_valid     = rdata_valid_q;
    assign o_busy            = busy_q;
    assign o_misaligned      = misaligned_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign o_err             = err_q;
`else
    assign o_err             = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a byte-level
// behavioural model. Timeout scenarios run only with MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_ctrl;

    localparam int unsigned LAT = 4;
    localparam int unsigned TO  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  o_mem_data_access;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_rdata;
    logic        o_rdata_valid;
    logic        o_busy;
    logic        o_misaligned;
    logic        o_err;

    int          n_checks = 0;
    int          n_bad    = 0;
    logic [31:0] exp_rdata = 32'd0;

    mem_access_ctrl #(
        .ACCESS_LAT(LAT),
        .TIMEOUT   (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_valid          (i_valid),
        .i_we             (i_we),
        .i_size           (i_size),
        .i_unsigned       (i_unsigned),
        .i_addr           (i_addr),
        .i_wdata          (i_wdata),
        .o_mem_data_access(o_mem_data_access),
        .o_mem_req        (o_mem_req),
        .o_mem_we         (o_mem_we),
        .o_mem_addr       (o_mem_addr),
        .o_mem_be         (o_mem_be),
        .o_mem_wdata      (o_mem_wdata),
        .i_mem_ack        (i_mem_ack),
        .i_mem_rdata      (i_mem_rdata),
        .o_rdata          (o_rdata),
        .o_rdata_valid    (o_rdata_valid),
        .o_busy           (o_busy),
        .o_misaligned     (o_misaligned),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_ok(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr[1:0]);
        return (size != 2'b11) && ((off % nbytes(size)) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] off_b);
        logic [3:0] be;
        int off = int'(off_b);
        for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + nbytes(size));
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = wd[8*(b % nbytes(size)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off_b, input logic [31:0] rd);
        longint v = 0;
        int n = nbytes(size);
        int off = int'(off_b);
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(rd[8*(off+i) +: 8]);
        if (!uns && v >= (64'd1 << (8*n - 1))) v = v - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    // ---------------- stimulus ----------------
    // Starts and ends on a falling edge. ack_dly = BUS cycles before ack is driven.
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_dly, input logic [31:0] rd);
        logic ok = model_ok(size, addr);
        logic [3:0] be = model_be(size, addr[1:0]);
        i_valid = 1'b1; i_we = we; i_size = size; i_unsigned = uns;
        i_addr = addr; i_wdata = wd;
        @(negedge clk);
        i_valid = 1'b0;
        if (!ok) begin
            check_eq("misaligned_pulse", 32'(o_misaligned), 32'd1);
            check_eq("misaligned_req", 32'(o_mem_req), 32'd0);
            check_eq("misaligned_busy", 32'(o_busy), 32'd0);
            check_eq("misaligned_lat", 32'(o_mem_data_access), 32'd0);
            @(negedge clk);
            check_eq("misaligned_end", 32'(o_misaligned), 32'd0);
            check_eq("misaligned_req2", 32'(o_mem_req), 32'd0);
            return;
        end
        check_eq("lat_pulse", 32'(o_mem_data_access), LAT);
        check_eq("req", 32'(o_mem_req), 32'd1);
        check_eq("busy", 32'(o_busy), 32'd1);
        check_eq("mem_we", 32'(o_mem_we), 32'(we));
        check_eq("mem_addr", o_mem_addr, {addr[31:2], 2'b00});
        check_eq("mem_be", 32'(o_mem_be), 32'(be));
        if (we) check_eq("mem_wdata", o_mem_wdata, model_wdata(size, wd));
        // Junk request while busy must be ignored.
        i_valid = 1'($urandom); i_addr = $urandom; i_we = 1'($urandom);
        i_size = 2'($urandom_range(0, 3)); i_wdata = $urandom;
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge clk);
            check_eq("req_hold", 32'(o_mem_req), 32'd1);
            check_eq("lat_zero", 32'(o_mem_data_access), 32'd0);
            check_eq("addr_hold", o_mem_addr, {addr[31:2], 2'b00});
            check_eq("be_hold", 32'(o_mem_be), 32'(be));
            check_eq("err_quiet", 32'(o_err), 32'd0);
        end
        i_mem_ack = 1'b1; i_mem_rdata = rd;
        @(negedge clk);
        i_mem_ack = 1'b0; i_valid = 1'b0; i_mem_rdata = $urandom;
        if (!we) exp_rdata = model_load(size, uns, addr[1:0], rd);
        check_eq("done_req", 32'(o_mem_req), 32'd0);
        check_eq("done_busy", 32'(o_busy), 32'd1);
        check_eq("done_valid", 32'(o_rdata_valid), 32'(!we));
        check_eq("rdata", o_rdata, exp_rdata);
        check_eq("done_err", 32'(o_err), 32'd0);
        @(negedge clk);
        check_eq("idle_busy", 32'(o_busy), 32'd0);
        check_eq("idle_valid", 32'(o_rdata_valid), 32'd0);
        check_eq("idle_req", 32'(o_mem_req), 32'd0);
        check_eq("rdata_hold", o_rdata, exp_rdata);
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic do_timeout(input logic [31:0] addr);
        i_valid = 1'b1; i_we = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
        i_addr = addr; i_wdata = 32'd0;
        @(negedge clk);
        i_valid = 1'b0;
        check_eq("to_req0", 32'(o_mem_req), 32'd1);
        for (int k = 1; k < int'(TO); k++) begin
            @(negedge clk);
            check_eq("to_req", 32'(o_mem_req), 32'd1);
            check_eq("to_err_early", 32'(o_err), 32'd0);
        end
        @(negedge clk);
        check_eq("to_err", 32'(o_err), 32'd1);
        check_eq("to_req_drop", 32'(o_mem_req), 32'd0);
        check_eq("to_busy", 32'(o_busy), 32'd0);
        check_eq("to_valid", 32'(o_rdata_valid), 32'd0);
        @(negedge clk);
        check_eq("to_err_end", 32'(o_err), 32'd0);
        check_eq("to_req_after", 32'(o_mem_req), 32'd0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_we = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
        i_addr = 32'd0; i_wdata = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
        #23;
        check_eq("rst_req", 32'(o_mem_req), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_rdata", o_rdata, 32'd0);
        check_eq("rst_lat", 32'(o_mem_data_access), 32'd0);
        check_eq("rst_err", 32'(o_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_access(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 3, 32'h80FF_FF11);
        check_eq("dir_byte_load", o_rdata, 32'hFFFF_FF80);
        do_access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 1, 32'd0);
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 0, 32'd0);
        do_access(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'd0, 0, 32'd0);
        do_access(1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'd0, 0, 32'h8765_4321);

        // Ack while idle must be ignored.
        i_mem_ack = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        i_mem_ack = 1'b0;
        check_eq("idle_ack_valid", 32'(o_rdata_valid), 32'd0);
        check_eq("idle_ack_rdata", o_rdata, exp_rdata);
        check_eq("idle_ack_busy", 32'(o_busy), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            do_access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                      $urandom, $urandom_range(0, 5), $urandom);
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        do_timeout(32'h0000_5000);
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'd0, int'(TO) - 1, 32'h1234_5678);
`endif

        // Reset in the middle of a bus access.
        i_valid = 1'b1; i_we = 1'b0; i_size = 2'b10; i_addr = 32'h0000_0040;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("midbus_req_before", 32'(o_mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("midbus_req_async", 32'(o_mem_req), 32'd0);
        check_eq("midbus_busy_async", 32'(o_busy), 32'd0);
        check_eq("midbus_rdata_async", o_rdata, 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'd0, 2, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: `ACCESS_LAT`, default 4, nominal bus cycles per access reported to the stall logic (1..15); `TIMEOUT`, default 15, maximum wait cycles for `i_mem_ack` (1..255).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `i_valid`, in, 1: MEM-stage access request.
- `i_we`, in, 1: 1 = store, 0 = load.
- `i_size`, in, 2: 00 byte, 01 half, 10 word, 11 reserved.
- `i_unsigned`, in, 1: zero-extend loads.
- `i_addr`, in, 32: byte address.
- `i_wdata`, in, 32: store data, right-aligned.
- `o_mem_data_access`, out, 4: cycle count for the stall controller, one-cycle pulse.
- `o_mem_req`, out, 1: bus request.
- `o_mem_we`, out, 1: bus write.
- `o_mem_addr`, out, 32: word-aligned address.
- `o_mem_be`, out, 4: byte enables.
- `o_mem_wdata`, out, 32: lane-replicated store data.
- `i_mem_ack`, in, 1: bus completion.
- `i_mem_rdata`, in, 32: bus read word.
- `o_rdata`, out, 32: extended load result.
- `o_rdata_valid`, out, 1: load result strobe.
- `o_busy`, out, 1: access in flight.
- `o_misaligned`, out, 1: alignment fault pulse.
- `o_err`, out, 1: timeout fault pulse.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUS and DONE; the reset state is IDLE.
REQ-004 In IDLE, with `i_valid`=1 and an aligned access (byte: any address; half: `addr[0]`=0; word: `addr[1:0]`=0), the block SHALL register the address, BE, write data and control, and enter BUS on the next edge.
REQ-005 A misaligned access, or `i_size`=11, SHALL pulse `o_misaligned` for one cycle, issue no bus request and stay in IDLE.
REQ-006 On accepting an access, `o_mem_data_access` SHALL equal `ACCESS_LAT` for exactly one cycle (the cycle BUS is entered); at all other times it SHALL be 0.
REQ-007 In BUS, `o_mem_req`=1 and `o_busy`=1, with all `o_mem_*` outputs held stable until the cycle `i_mem_ack`=1.
REQ-008 Byte enables:
- byte: `4'b0001` shifted left by `addr[1:0]`.
- half: `4'b0011` shifted left by `addr[1:0]`.
- word: `4'b1111`.
REQ-009 `o_mem_wdata` SHALL be: byte replicated ×4, half replicated ×2, word unchanged; `o_mem_addr` = `{addr[31:2], 2'b00}`.
REQ-010 On `i_mem_ack` in BUS, a load SHALL capture the selected lane of `i_mem_rdata`, sign- or zero-extended per `i_unsigned`, into `o_rdata`; the FSM then enters DONE.
REQ-011 In DONE, for one cycle, `o_rdata_valid`=1 (loads only), `o_mem_req`=0, `o_busy`=1; the FSM then returns to IDLE. Back-to-back access latency is therefore ack + 2 cycles minimum.
REQ-012 `o_rdata` SHALL hold its value until the next load completes.
REQ-013 `i_valid` SHALL be ignored outside IDLE; no queueing.
REQ-014 `i_mem_ack` SHALL be ignored outside BUS.
REQ-015 An ack in the first BUS cycle SHALL be accepted (single-cycle bus legal).

Reset
REQ-016 Asserting `rst` (low) SHALL asynchronously force: state IDLE, every output 0, the timeout counter 0. This includes reset mid-BUS, where `o_mem_req` drops without waiting for the edge.
REQ-017 After `rst` deasserts, the first access SHALL be accepted no earlier than the first rising edge.

Configuration
REQ-018 With `MEM_ACCESS_TIMEOUT_EN` defined:
- an 8-bit counter clears on BUS entry and increments each BUS cycle without ack.
- on reaching `TIMEOUT`, the block SHALL drop `o_mem_req`, pulse `o_err` for one cycle, suppress `o_rdata_valid`, and go to IDLE.
- an ack arriving in the same cycle as the counter reaching `TIMEOUT` SHALL win: normal completion, no `o_err`.
REQ-019 With `MEM_ACCESS_TIMEOUT_EN` undefined: no counter is built, `o_err` is tied to 0, and BUS waits indefinitely.

Verification
REQ-020 Load byte: `addr`=0x1003, unsigned=0, `rdata`=0x80FF_FF_11, ack after 3 cycles -> `be`=1000, `o_rdata`=0xFFFF_FF80, `valid` 1 cycle, `o_mem_data_access`=4 for one cycle.
REQ-021 Store half: `addr`=0x2002, `wdata`=0x0000_BEEF -> `o_mem_be`=1100, `o_mem_wdata`=0xBEEF_BEEF, `o_mem_we`=1, no `o_rdata_valid`.
REQ-022 Misaligned word: `addr`=0x3001 -> `o_misaligned` pulse, `o_mem_req` never asserts, `o_busy`=0.
REQ-023 Timeout (macro on, `TIMEOUT`=15): no ack -> `o_err` pulses 15 cycles after BUS entry, `o_mem_req`=0 afterwards; with ack in that same cycle -> no `o_err`.
REQ-024 Reset mid-BUS: `rst` low 2 cycles into BUS -> `o_mem_req`=0 immediately. After release, `i_valid` with a word load at 0x0 completes normally.
REQ-025 Busy rejection: a second `i_valid` while in BUS -> ignored; exactly one bus transaction observed.
